// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB bus encodings and responder FSM states shared by the memory slave
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } ahb_state_e;

    // The 4-bit shift context truncates lanes that fall off the top of the word.
    function automatic logic [3:0] ahb_byte_en(input logic [2:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << lane;
            HSIZE_HALF: be = 4'b0011 << lane;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_slv_byte_mem.sv
// rtl/ahb_slv_byte_mem.sv - word-addressed scratch RAM, byte-enable synchronous write, async read
module ahb_slv_byte_mem #(
    parameter int MEM_DEPTH = 256,
    parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_mem_slave.sv
// rtl/ahb_mem_slave.sv - AHB scratch-memory responder with programmable wait states
// Define AHB_MEM_SLAVE_ERR_CHECK_EN to enable ERROR responses for illegal transfers.
module ahb_mem_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready,
    output logic                  hready_resp,
    output logic [1:0]            hresp,
    output logic [DATA_WIDTH-1:0] hrdata
);

    import ahb_pkg::*;

    localparam int         IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES - 1);

    ahb_state_e       state;
    logic [3:0]       wcnt;
    logic [IDX_W-1:0] addr_q;
    logic [1:0]       lane_q;
    logic [2:0]       size_q;
    logic             write_q;
    logic             accept;
    logic             mem_we;
    logic [31:0]      rd_data;
    logic             unused_ok;

    assign accept    = hsel & hready & (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    assign unused_ok = ^{hburst, haddr};

`ifdef AHB_MEM_SLAVE_ERR_CHECK_EN
    logic                  acc_err;
    logic [ADDR_WIDTH-1:0] word_idx;

    assign word_idx = haddr >> 2;

    always_comb begin
        acc_err = 1'b0;
        if (hsize > HSIZE_WORD)
            acc_err = 1'b1;
        else if (hsize == HSIZE_HALF && haddr[0])
            acc_err = 1'b1;
        else if (hsize == HSIZE_WORD && haddr[1:0] != 2'b00)
            acc_err = 1'b1;
        if (word_idx >= ADDR_WIDTH'(MEM_DEPTH))
            acc_err = 1'b1;
    end
`endif

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state       <= ST_IDLE;
            wcnt        <= 4'd0;
            hready_resp <= 1'b1;
            hresp       <= HRESP_OKAY;
            addr_q      <= '0;
            lane_q      <= 2'b00;
            size_q      <= HSIZE_BYTE;
            write_q     <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wcnt == 4'd0) begin
                        state       <= ST_DATA;
                        hready_resp <= 1'b1;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
`ifdef AHB_MEM_SLAVE_ERR_CHECK_EN
                ST_ERR1: begin
                    state       <= ST_ERR2;
                    hready_resp <= 1'b1;
                    hresp       <= HRESP_ERROR;
                end
`endif
                // IDLE, DATA and ERR2 all sample the next address phase.
                default: begin
                    if (accept) begin
                        addr_q  <= haddr[IDX_W+1:2];
                        lane_q  <= haddr[1:0];
                        size_q  <= hsize;
                        write_q <= hwrite;
`ifdef AHB_MEM_SLAVE_ERR_CHECK_EN
                        if (acc_err) begin
                            state       <= ST_ERR1;
                            hready_resp <= 1'b0;
                            hresp       <= HRESP_ERROR;
                        end else
`endif
                        if (WAIT_STATES > 0) begin
                            state       <= ST_WAIT;
                            wcnt        <= WAIT_INIT;
                            hready_resp <= 1'b0;
                            hresp       <= HRESP_OKAY;
                        end else begin
                            state       <= ST_DATA;
                            hready_resp <= 1'b1;
                            hresp       <= HRESP_OKAY;
                        end
                    end else begin
                        state       <= ST_IDLE;
                        hready_resp <= 1'b1;
                        hresp       <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    // Reset on the committing edge drops the write.
    assign mem_we = (state == ST_DATA) && write_q && !hreset;

    ahb_slv_byte_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .IDX_W     (IDX_W)
    ) u_mem (
        .clk   (hclk),
        .we    (mem_we),
        .be    (ahb_byte_en(size_q, lane_q)),
        .addr  (addr_q),
        .wdata (hwdata),
        .rdata (rd_data)
    );

    assign hrdata = (state == ST_DATA && !write_q) ? rd_data : '0;

endmodule
